// File: rtl/alu_pkg.sv
// Opcode constants and arbiter FSM states, shared by the ALU and the arbiter
// that feeds it.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PASS = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_DEC  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_NOR  = 4'hA;
    localparam logic [3:0] OP_XOR  = 4'hB;
    localparam logic [3:0] OP_XNOR = 4'hC;
    localparam logic [3:0] OP_MAX  = 4'hD;
    localparam logic [3:0] OP_MIN  = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when the operation yields no value: NOP, or an equality test that misses.
    function automatic logic is_none(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return (op == OP_NOP) || ((op == OP_EQ) && (a != b));
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; all arithmetic wraps modulo 256 and comparisons
// are unsigned. Operations with no value drive zero.
module alu
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (op)
            OP_NOP:  y = 8'h00;
            OP_PASS: y = a;
            OP_INC:  y = a + 8'd1;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_DEC:  y = a - 8'd1;
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_MAX:  y = (a > b) ? a : b;
            OP_MIN:  y = (a < b) ? a : b;
            OP_EQ:   y = (a == b) ? a : 8'h00;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU: one operation in
// flight, result held until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NREQ-1:0]   req_valid_in,
    input  logic [NREQ*8-1:0] req_a_in,
    input  logic [NREQ*8-1:0] req_b_in,
    input  logic [NREQ*4-1:0] req_op_in,
    output logic [NREQ-1:0]   req_ready_out,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic [7:0]        res_data_out,
    output logic              res_none_out,
    output logic [1:0]        res_id_out,
    output logic [15:0]       op_count_out
);

    state_t      state_reg, state_next;
    logic [1:0]  rr_ptr_reg;
    logic [7:0]  a_reg, b_reg;
    logic [3:0]  op_reg;
    logic [1:0]  id_reg;
    logic [7:0]  res_data_reg;
    logic        res_none_reg;
    logic [1:0]  res_id_reg;
    logic [15:0] op_count_reg;

    logic [3:0]  valid_pad;
    logic [7:0]  a_arr  [4];
    logic [7:0]  b_arr  [4];
    logic [3:0]  op_arr [4];
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic        grant_any;
    logic        grant_en;
    logic        consume;
    logic [7:0]  alu_y;

    // Unpack requesters into a fixed 4-slot view so a 2-bit index works for any NREQ.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            if (gi < NREQ) begin : g_used
                assign valid_pad[gi] = req_valid_in[gi];
                assign a_arr[gi]     = req_a_in[8*gi +: 8];
                assign b_arr[gi]     = req_b_in[8*gi +: 8];
                assign op_arr[gi]    = req_op_in[4*gi +: 4];
            end else begin : g_unused
                assign valid_pad[gi] = 1'b0;
                assign a_arr[gi]     = 8'h00;
                assign b_arr[gi]     = 8'h00;
                assign op_arr[gi]    = 4'h0;
            end
        end
    endgenerate

    // Walk backwards so the candidate closest to the pointer is the one kept.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = 2'((int'(rr_ptr_reg) + k) % NREQ);
            if (valid_pad[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_en   = 1'b0;
        consume    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any && !rst_in) begin
                    grant_en   = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (res_ready_in) begin
                    consume    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready_out[gi] = grant_en && (grant_idx == 2'(gi));
        end
    endgenerate

    alu u_alu (
        .a  (a_reg),
        .b  (b_reg),
        .op (op_reg),
        .y  (alu_y)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr_reg   <= 2'd0;
            a_reg        <= 8'h00;
            b_reg        <= 8'h00;
            op_reg       <= OP_NOP;
            id_reg       <= 2'd0;
            res_data_reg <= 8'h00;
            res_none_reg <= 1'b0;
            res_id_reg   <= 2'd0;
            op_count_reg <= 16'h0000;
        end else begin
            if (grant_en) begin
                a_reg      <= a_arr[grant_idx];
                b_reg      <= b_arr[grant_idx];
                op_reg     <= op_arr[grant_idx];
                id_reg     <= grant_idx;
                rr_ptr_reg <= (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;
            end
            if (state_reg == EXEC) begin
                res_none_reg <= is_none(op_reg, a_reg, b_reg);
                res_data_reg <= is_none(op_reg, a_reg, b_reg) ? 8'h00 : alu_y;
                res_id_reg   <= id_reg;
            end
            if (consume) begin
                op_count_reg <= op_count_reg + 16'd1;
            end
        end
    end

    assign res_valid_out = (state_reg == RESP);
    assign res_data_out  = res_data_reg;
    assign res_none_out  = res_none_reg;
    assign res_id_out    = res_id_reg;
    assign op_count_out  = op_count_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_alu_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_in;
    logic [N-1:0]   req_valid_in;
    logic [N*8-1:0] req_a_in;
    logic [N*8-1:0] req_b_in;
    logic [N*4-1:0] req_op_in;
    logic [N-1:0]   req_ready_out;
    logic           res_valid_out;
    logic           res_ready_in;
    logic [7:0]     res_data_out;
    logic           res_none_out;
    logic [1:0]     res_id_out;
    logic [15:0]    op_count_out;

    alu_arbiter #(.NREQ(N)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_a_in      (req_a_in),
        .req_b_in      (req_b_in),
        .req_op_in     (req_op_in),
        .req_ready_out (req_ready_out),
        .res_valid_out (res_valid_out),
        .res_ready_in  (res_ready_in),
        .res_data_out  (res_data_out),
        .res_none_out  (res_none_out),
        .res_id_out    (res_id_out),
        .op_count_out  (op_count_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int model_count = 0;
    int model_ptr = 0;
    int gcyc = 0;
    int fa [N];
    int fb [N];
    int fo [N];

    typedef struct {
        int ridx;
        int a;
        int b;
        int op;
        int hold;
        int data;
        int none;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU written from the opcode table with plain integer arithmetic.
    function automatic void ref_alu(input int a, input int b, input int op, output int data, output int none);
        none = 0;
        data = 0;
        case (op)
            0:  none = 1;
            1:  data = a;
            2:  data = (a + 1) % 256;
            3:  data = (a + b) % 256;
            4:  data = (a - b + 256) % 256;
            5:  data = (a + 255) % 256;
            6:  data = 255 - a;
            7:  data = a & b;
            8:  data = 255 - (a & b);
            9:  data = a | b;
            10: data = 255 - (a | b);
            11: data = a ^ b;
            12: data = 255 - (a ^ b);
            13: data = (a > b) ? a : b;
            14: data = (a < b) ? a : b;
            default: begin
                if (a == b) data = a;
                else none = 1;
            end
        endcase
    endfunction

    function automatic int ref_pick(input int mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int v, input int a, input int b, input int op);
        req_valid_in[i]      = v[0];
        req_a_in[8*i +: 8]   = a[7:0];
        req_b_in[8*i +: 8]   = b[7:0];
        req_op_in[4*i +: 4]  = op[3:0];
    endtask

    task automatic do_reset();
        rst_in       = 1'b1;
        res_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_in      = 1'b0;
        model_count = 0;
        model_ptr   = 0;
    endtask

    // Waits (bounded) for a grant and checks it is the expected one-hot strobe.
    task automatic get_grant(input int exp_idx, input string tag);
        bit seen = 1'b0;
        #1;
        for (int t = 0; t < 12; t++) begin
            if (req_ready_out != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        gcyc = cyc;
        check({tag, " grant_seen"}, 32'(seen), 32'd1);
        check({tag, " req_ready"}, 32'(req_ready_out), 32'(1 << exp_idx));
        model_ptr = (exp_idx + 1) % N;
    endtask

    // Follows a granted operation through to consumption.
    task automatic get_result(input int exp_data, input int exp_none, input int exp_id, input int hold,
                              input int drop, input int add, input string tag);
        bit         seen = 1'b0;
        logic [7:0] d0;
        logic       n0;
        logic [1:0] i0;
        @(negedge clk);
        if (drop >= 0) req_valid_in[drop] = 1'b0;
        if (add >= 0) req_valid_in[add] = 1'b1;
        #1;
        for (int t = 0; t < 12; t++) begin
            if (res_valid_out) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check({tag, " res_valid_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc - gcyc), 32'd2);
        check({tag, " res_data"}, 32'(res_data_out), 32'(exp_data));
        check({tag, " res_none"}, 32'(res_none_out), 32'(exp_none));
        check({tag, " res_id"}, 32'(res_id_out), 32'(exp_id));
        d0 = res_data_out;
        n0 = res_none_out;
        i0 = res_id_out;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check({tag, " hold_stable"}, {21'd0, res_valid_out, d0 ^ res_data_out, n0 ^ res_none_out, i0 ^ res_id_out},
                  {21'd0, 1'b1, 8'h00, 1'b0, 2'd0});
            check({tag, " hold_no_grant"}, 32'(req_ready_out), 32'd0);
        end
        res_ready_in = 1'b1;
        @(negedge clk);
        res_ready_in = 1'b0;
        #1;
        model_count = (model_count + 1) % 65536;
        check({tag, " op_count"}, 32'(op_count_out), 32'(model_count));
        check({tag, " res_valid_drop"}, 32'(res_valid_out), 32'd0);
        $display("txn %s: id=%0d data=%02h none=%0d count=%0d", tag, i0, d0, n0, op_count_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ed, en, mask, exp_idx, hold;
        bit rose;

        vecs[0]  = '{0, 'h05, 'h03, 3,  1, 'h08, 0};
        vecs[1]  = '{1, 'h10, 'h11, 15, 0, 'h00, 1};
        vecs[2]  = '{1, 'h10, 'h10, 15, 2, 'h10, 0};
        vecs[3]  = '{0, 'h00, 'h01, 4,  0, 'hFF, 0};
        vecs[4]  = '{2, 'h80, 'h7F, 13, 0, 'h80, 0};
        vecs[5]  = '{0, 'h80, 'h7F, 14, 0, 'h7F, 0};
        vecs[6]  = '{1, 'h00, 'h55, 5,  0, 'hFF, 0};
        vecs[7]  = '{2, 'hA5, 'h5A, 6,  1, 'h5A, 0};
        vecs[8]  = '{0, 'hF0, 'h3C, 8,  0, 'hCF, 0};
        vecs[9]  = '{1, 'hF0, 'h3C, 12, 0, 'h33, 0};
        vecs[10] = '{2, 'h12, 'h34, 0,  0, 'h00, 1};
        vecs[11] = '{0, 'hF0, 'h0F, 10, 0, 'h00, 0};
        vecs[12] = '{1, 'h7F, 'h01, 3,  0, 'h80, 0};

        // Reset with every requester asserting: nothing may be granted.
        rst_in       = 1'b1;
        res_ready_in = 1'b0;
        req_valid_in = '1;
        req_a_in     = '0;
        req_b_in     = '0;
        req_op_in    = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset req_ready", 32'(req_ready_out), 32'd0);
        check("reset res_valid", 32'(res_valid_out), 32'd0);
        check("reset res_data", 32'(res_data_out), 32'd0);
        check("reset res_none", 32'(res_none_out), 32'd0);
        check("reset res_id", 32'(res_id_out), 32'd0);
        check("reset op_count", 32'(op_count_out), 32'd0);
        req_valid_in = '0;
        rst_in       = 1'b0;
        model_count  = 0;
        model_ptr    = 0;

        // Directed vector table, one requester at a time.
        for (int v = 0; v < 13; v++) begin
            set_req(vecs[v].ridx, 1, vecs[v].a, vecs[v].b, vecs[v].op);
            if (v == 0) begin
                #1;
                check("first_cycle_grant", 32'(req_ready_out), 32'd1);
            end
            get_grant(vecs[v].ridx, $sformatf("vec%0d", v));
            get_result(vecs[v].data, vecs[v].none, vecs[v].ridx, vecs[v].hold, vecs[v].ridx, -1,
                       $sformatf("vec%0d", v));
        end

        // Consumer stalls 5 cycles while req0 waits; req0 must win right after consume.
        set_req(0, 0, 'h21, 'h02, 4);
        set_req(1, 1, 'h02, 'h03, 3);
        get_grant(1, "stall");
        get_result('h05, 0, 1, 5, 1, 0, "stall");
        check("stall next_grant", 32'(req_ready_out), 32'd1);
        get_grant(0, "stall_req0");
        get_result('h1F, 0, 0, 0, 0, -1, "stall_req0");

        // Two requesters held valid: grants alternate, increment wraps FF to 00.
        do_reset();
        set_req(0, 1, 'hFF, 'h00, 2);
        set_req(1, 1, 'hFF, 'h00, 2);
        for (int k = 0; k < 4; k++) begin
            get_grant(k % 2, $sformatf("alt%0d", k));
            get_result('h00, 0, k % 2, 0, -1, -1, $sformatf("alt%0d", k));
        end
        check("alt op_count4", 32'(op_count_out), 32'd4);
        req_valid_in = '0;

        // Reset while the operation is in EXEC discards it and rewinds the pointer.
        @(negedge clk);
        do_reset();
        set_req(0, 1, 'h01, 'h01, 3);
        get_grant(0, "abort");
        @(negedge clk);
        req_valid_in = '0;
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        model_count = 0;
        model_ptr   = 0;
        rose = 1'b0;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (res_valid_out) rose = 1'b1;
            @(negedge clk);
        end
        check("abort res_valid_never", 32'(rose), 32'd0);
        check("abort op_count", 32'(op_count_out), 32'd0);
        set_req(0, 1, 'h09, 'h0A, 14);
        set_req(1, 1, 'h09, 'h0A, 13);
        get_grant(0, "abort_next");
        get_result('h09, 0, 0, 0, 0, -1, "abort_next");
        req_valid_in = '0;

        // Randomized traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            mask = $urandom_range(1, (1 << N) - 1);
            for (int i = 0; i < N; i++) begin
                fa[i] = $urandom_range(0, 255);
                fb[i] = ($urandom_range(0, 3) == 0) ? fa[i] : $urandom_range(0, 255);
                fo[i] = $urandom_range(0, 15);
                set_req(i, mask[i], fa[i], fb[i], fo[i]);
            end
            exp_idx = ref_pick(mask, model_ptr);
            ref_alu(fa[exp_idx], fb[exp_idx], fo[exp_idx], ed, en);
            hold = $urandom_range(0, 3);
            get_grant(exp_idx, $sformatf("rnd%0d", it));
            get_result(ed, en, exp_idx, hold, exp_idx, -1, $sformatf("rnd%0d", it));
        end
        req_valid_in = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters; legal range 2..4.
REQ-002 Port: clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_in  input  1  reset, synchronous, active-high.
REQ-004 Port: req_valid_in  input  NREQ  per-requester request valid.
REQ-005 Port: req_a_in  input  NREQ*8  per-requester operand A; requester i uses bits [8i+7:8i].
REQ-006 Port: req_b_in  input  NREQ*8  per-requester operand B; same packing as REQ-005.
REQ-007 Port: req_op_in  input  NREQ*4  per-requester ALU opcode; requester i uses bits [4i+3:4i].
REQ-008 Port: req_ready_out  output  NREQ  one-hot accept strobe; at most one bit high per cycle.
REQ-009 Port: res_valid_out  output  1  result valid.
REQ-010 Port: res_ready_in  input  1  result consumer ready.
REQ-011 Port: res_data_out  output  8  ALU result.
REQ-012 Port: res_none_out  output  1  operation produced no value (NOP, or equality miss).
REQ-013 Port: res_id_out  output  2  index of the requester that owns the result.
REQ-014 Port: op_count_out  output  16  count of completed (consumed) results.

Function
REQ-015 FSM states IDLE, EXEC, RESP; exactly one operation in flight at any time.
REQ-016 IDLE: if any req_valid_in bit is high, grant one requester by round-robin, pulse its req_ready_out for 1 cycle, latch its a/b/op and index, go to EXEC.
REQ-017 Round-robin: search starts at (last granted index + 1) mod NREQ; after reset, search starts at index 0.
REQ-018 A request is accepted only on a cycle where req_valid_in[i] and req_ready_out[i] are both high; requesters hold their fields until accepted.
REQ-019 EXEC: latched operands drive the ALU sub-module; its output is registered into res_data_out; go to RESP; res_valid_out high from the next cycle.
REQ-020 Latency: accept at cycle N gives res_valid_out high at cycle N+2.
REQ-021 ALU opcodes: 0 NOP, 1 pass A, 2 A+1, 3 A+B, 4 A-B, 5 A-1, 6 ~A, 7 AND, 8 NAND, 9 OR, A NOR, B XOR, C XNOR, D max, E min, F A if A==B; all arithmetic is 8-bit modulo 256, with no carry or borrow out.
REQ-022 Opcode 0, and opcode F with A!=B: res_data_out = 8'h00 and res_none_out = 1; the high-Z value is never registered. For all other cases res_none_out = 0.
REQ-023 RESP: res_valid_out, res_data_out, res_none_out and res_id_out hold stable until res_valid_out && res_ready_in; on that cycle, increment op_count_out (wrapping FFFF->0000) and go to IDLE.
REQ-024 No grant is issued in EXEC or RESP; the earliest new grant is the cycle after the result is consumed.
REQ-025 A requester that drops req_valid_in before being accepted has no effect; one that stays valid is granted within NREQ grants.
REQ-026 req_ready_out is driven only from state; it has no combinational path from res_ready_in.

Reset
REQ-027 While rst_in is high at a clock edge: state = IDLE; req_ready_out = 0; res_valid_out = 0; res_data_out = 8'h00; res_none_out = 0; res_id_out = 0; op_count_out = 0; round-robin pointer = 0.
REQ-028 Reset asserted mid-operation (in EXEC or RESP) discards the in-flight operation: no result is delivered and op_count_out is not incremented.

Structure
REQ-029 Shared package alu_pkg holds the opcode constants (OP_NOP .. OP_EQ) and the FSM state enum; the existing ALU uses the same constants.
REQ-030 Exactly one sub-module, the existing combinational alu, is instantiated once; the arbiter does not duplicate ALU logic except for the A==B compare that drives res_none_out.

Verification
REQ-031 Reset, then req0 valid with A=8'h05, B=8'h03, op=3 -> req_ready_out=01 at cycle 1; res_valid_out at cycle 3 with data 8'h08, none=0, id=0; after consume, op_count_out=1.
REQ-032 Both requesters valid continuously, each with op=2, A=8'hFF -> grants alternate 0,1,0,1; every result is 8'h00 (wrap-around); op_count_out=4 after 4 results.
REQ-033 req1 op=F with A=8'h10, B=8'h11 -> res_none_out=1, res_data_out=8'h00; repeat with B=8'h10 -> data 8'h10, none=0.
REQ-034 res_ready_in held low 5 cycles in RESP -> outputs stable, no req_ready_out pulses, pending req0 granted the cycle after consume.
REQ-035 rst_in pulsed during EXEC -> res_valid_out never rises for that operation; op_count_out=0; the next grant goes to index 0.
REQ-036 Op=4 with A=8'h00, B=8'h01 -> 8'hFF; op=D with A=8'h80, B=8'h7F -> 8'h80 (unsigned compare).
